// File: rtl/gnn_pkg.sv
// rtl/gnn_pkg.sv - shared sizes and state encoding for the gnn frame loader
package gnn_pkg;

  localparam int DATA_W    = 5;
  localparam int NUM_NODES = 4;
  localparam int NUM_FEAT  = 4;
  localparam int NUM_HID   = 4;
  localparam int NUM_OUT   = 2;
  localparam int FRAME_LEN = NUM_NODES*NUM_FEAT + NUM_FEAT*NUM_HID + NUM_HID*NUM_OUT;
  localparam int IDX_W     = 6;
  localparam int FLAG_W    = NUM_OUT*NUM_NODES;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/gnn_ready_tracker.sv
// rtl/gnn_ready_tracker.sv - sticky ready-flag mask and RUN timeout counter
module gnn_ready_tracker
  import gnn_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [FLAG_W-1:0] flags,
  output logic              complete,
  output logic              timeout
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [FLAG_W-1:0] mask_q;
  logic [CNT_W-1:0]  cnt_q;

  // Leaving RUN clears both, so every frame starts with a fresh mask and budget.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= '0;
      cnt_q  <= '0;
    end else if (run) begin
      mask_q <= mask_q | flags;
      cnt_q  <= cnt_q + CNT_W'(1);
    end else begin
      mask_q <= '0;
      cnt_q  <= '0;
    end
  end

  assign complete = run & (&(mask_q | flags));
  assign timeout  = run & (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/gnn_loader.sv
// rtl/gnn_loader.sv - loads a 40-beat feature/weight frame and hands it to the gnn stage
module gnn_loader
  import gnn_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  input  logic signed [DATA_W-1:0] s_data,
  input  logic                     s_last,
  output logic                     s_ready,
  output logic signed [DATA_W-1:0] x0_node0, x1_node0, x2_node0, x3_node0,
  output logic signed [DATA_W-1:0] x0_node1, x1_node1, x2_node1, x3_node1,
  output logic signed [DATA_W-1:0] x0_node2, x1_node2, x2_node2, x3_node2,
  output logic signed [DATA_W-1:0] x0_node3, x1_node3, x2_node3, x3_node3,
  output logic signed [DATA_W-1:0] w04, w14, w24, w34,
  output logic signed [DATA_W-1:0] w05, w15, w25, w35,
  output logic signed [DATA_W-1:0] w06, w16, w26, w36,
  output logic signed [DATA_W-1:0] w07, w17, w27, w37,
  output logic signed [DATA_W-1:0] w48, w58, w68, w78,
  output logic signed [DATA_W-1:0] w49, w59, w69, w79,
  output logic                     in_ready,
  input  logic                     out0_ready_node0, out0_ready_node1,
  input  logic                     out0_ready_node2, out0_ready_node3,
  input  logic                     out1_ready_node0, out1_ready_node1,
  input  logic                     out1_ready_node2, out1_ready_node3,
  output logic                     done,
  output logic                     err,
  output logic                     busy
);

  localparam int               GAP_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic signed [DATA_W-1:0] slot_q [FRAME_LEN];

  logic beat, at_last, frame_ok, frame_bad;
  logic complete, timeout;
  logic s_ready_d, in_ready_d, busy_d, done_d, err_d;
  logic [FLAG_W-1:0] flags;

  assign flags = {out1_ready_node3, out1_ready_node2, out1_ready_node1, out1_ready_node0,
                  out0_ready_node3, out0_ready_node2, out0_ready_node1, out0_ready_node0};

  // s_ready is only ever high in LOAD, so a handshake implies LOAD.
  assign beat      = s_valid & s_ready;
  assign at_last   = (idx_q == LAST_IDX);
  assign frame_ok  = beat & at_last & s_last;
  assign frame_bad = beat & (at_last ^ s_last);

  gnn_ready_tracker #(.TIMEOUT(TIMEOUT)) u_tracker (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (state_q == ST_RUN),
    .flags    (flags),
    .complete (complete),
    .timeout  (timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LOAD;
      idx_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = '0;
    unique case (state_q)
      ST_LOAD: begin
        if (frame_ok) begin
          state_d = ST_RUN;
          idx_d   = '0;
        end else if (frame_bad) begin
          idx_d = '0;
        end else if (beat) begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_RUN: begin
        if (complete || timeout) state_d = ST_GAP;
      end
      ST_GAP: begin
        if (gap_q == GAP_W'(HOLD_CYCLES - 1)) state_d = ST_LOAD;
        else gap_d = gap_q + GAP_W'(1);
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // Outputs are registered from the next state so reset can hold them all low.
  always_comb begin
    s_ready_d  = (state_d == ST_LOAD);
    in_ready_d = (state_d == ST_RUN);
    busy_d     = (state_d != ST_LOAD);
    done_d     = (state_q == ST_RUN) & complete;
    err_d      = ((state_q == ST_LOAD) & frame_bad) |
                 ((state_q == ST_RUN) & timeout & ~complete);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ready  <= 1'b0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      s_ready  <= s_ready_d;
      in_ready <= in_ready_d;
      busy     <= busy_d;
      done     <= done_d;
      err      <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FRAME_LEN; i++) slot_q[i] <= '0;
    end else if (beat) begin
      slot_q[idx_q] <= s_data;
    end
  end

  assign {x0_node0, x1_node0, x2_node0, x3_node0} = {slot_q[0],  slot_q[1],  slot_q[2],  slot_q[3]};
  assign {x0_node1, x1_node1, x2_node1, x3_node1} = {slot_q[4],  slot_q[5],  slot_q[6],  slot_q[7]};
  assign {x0_node2, x1_node2, x2_node2, x3_node2} = {slot_q[8],  slot_q[9],  slot_q[10], slot_q[11]};
  assign {x0_node3, x1_node3, x2_node3, x3_node3} = {slot_q[12], slot_q[13], slot_q[14], slot_q[15]};
  assign {w04, w14, w24, w34} = {slot_q[16], slot_q[17], slot_q[18], slot_q[19]};
  assign {w05, w15, w25, w35} = {slot_q[20], slot_q[21], slot_q[22], slot_q[23]};
  assign {w06, w16, w26, w36} = {slot_q[24], slot_q[25], slot_q[26], slot_q[27]};
  assign {w07, w17, w27, w37} = {slot_q[28], slot_q[29], slot_q[30], slot_q[31]};
  assign {w48, w58, w68, w78} = {slot_q[32], slot_q[33], slot_q[34], slot_q[35]};
  assign {w49, w59, w69, w79} = {slot_q[36], slot_q[37], slot_q[38], slot_q[39]};

endmodule

// File: tb/tb_gnn_loader.sv
// tb/tb_gnn_loader.sv - directed self-checking bench for gnn_loader
module tb_gnn_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic s_valid = 1'b0;
  logic signed [4:0] s_data = '0;
  logic s_last = 1'b0;
  logic [7:0] fl = '0;
  logic s_ready, in_ready, done, err, busy;

  logic signed [4:0] x0_node0, x1_node0, x2_node0, x3_node0, x0_node1, x1_node1, x2_node1, x3_node1;
  logic signed [4:0] x0_node2, x1_node2, x2_node2, x3_node2, x0_node3, x1_node3, x2_node3, x3_node3;
  logic signed [4:0] w04, w14, w24, w34, w05, w15, w25, w35, w06, w16, w26, w36, w07, w17, w27, w37;
  logic signed [4:0] w48, w58, w68, w78, w49, w59, w69, w79;

  wire signed [4:0] obs [40];
  assign obs[0]  = x0_node0; assign obs[1]  = x1_node0; assign obs[2]  = x2_node0; assign obs[3]  = x3_node0;
  assign obs[4]  = x0_node1; assign obs[5]  = x1_node1; assign obs[6]  = x2_node1; assign obs[7]  = x3_node1;
  assign obs[8]  = x0_node2; assign obs[9]  = x1_node2; assign obs[10] = x2_node2; assign obs[11] = x3_node2;
  assign obs[12] = x0_node3; assign obs[13] = x1_node3; assign obs[14] = x2_node3; assign obs[15] = x3_node3;
  assign obs[16] = w04; assign obs[17] = w14; assign obs[18] = w24; assign obs[19] = w34;
  assign obs[20] = w05; assign obs[21] = w15; assign obs[22] = w25; assign obs[23] = w35;
  assign obs[24] = w06; assign obs[25] = w16; assign obs[26] = w26; assign obs[27] = w36;
  assign obs[28] = w07; assign obs[29] = w17; assign obs[30] = w27; assign obs[31] = w37;
  assign obs[32] = w48; assign obs[33] = w58; assign obs[34] = w68; assign obs[35] = w78;
  assign obs[36] = w49; assign obs[37] = w59; assign obs[38] = w69; assign obs[39] = w79;

  gnn_loader #(.HOLD_CYCLES(4), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .x0_node0(x0_node0), .x1_node0(x1_node0), .x2_node0(x2_node0), .x3_node0(x3_node0),
    .x0_node1(x0_node1), .x1_node1(x1_node1), .x2_node1(x2_node1), .x3_node1(x3_node1),
    .x0_node2(x0_node2), .x1_node2(x1_node2), .x2_node2(x2_node2), .x3_node2(x3_node2),
    .x0_node3(x0_node3), .x1_node3(x1_node3), .x2_node3(x2_node3), .x3_node3(x3_node3),
    .w04(w04), .w14(w14), .w24(w24), .w34(w34), .w05(w05), .w15(w15), .w25(w25), .w35(w35),
    .w06(w06), .w16(w16), .w26(w26), .w36(w36), .w07(w07), .w17(w17), .w27(w27), .w37(w37),
    .w48(w48), .w58(w58), .w68(w68), .w78(w78), .w49(w49), .w59(w59), .w69(w69), .w79(w79),
    .in_ready(in_ready),
    .out0_ready_node0(fl[0]), .out0_ready_node1(fl[1]), .out0_ready_node2(fl[2]), .out0_ready_node3(fl[3]),
    .out1_ready_node0(fl[4]), .out1_ready_node1(fl[5]), .out1_ready_node2(fl[6]), .out1_ready_node3(fl[7]),
    .done(done), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int tx [40];

  task automatic chk(input string tag, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Beats only count when s_valid is high; idle cycles carry junk payload and s_last.
  task automatic send(input int n, input int last_at, input bit toggle);
    int i = 0;
    bit idle = 1'b0;
    while (i < n) begin
      if (toggle && idle) begin
        s_valid = 1'b0; s_data = 5'sb00101; s_last = 1'b1;
      end else begin
        s_valid = 1'b1; s_data = tx[i][4:0]; s_last = (i == last_at);
      end
      tick();
      if (s_valid) i++;
      idle = toggle ? ~idle : 1'b0;
    end
    s_valid = 1'b0; s_last = 1'b0; s_data = '0;
  endtask

  task automatic check_slots(input string tag);
    for (int i = 0; i < 40; i++) chk($sformatf("%s[%0d]", tag, i), obs[i], tx[i]);
  endtask

  task automatic wait_load();
    for (int c = 0; c < 20 && !s_ready; c++) tick();
    chk("wait_load", s_ready, 1);
  endtask

  initial begin
    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_s_ready", s_ready, 0); chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_err", err, 0);
    chk("rst_x0n0", obs[0], 0); chk("rst_w79", obs[39], 0);
    tick(); tick();
    rst_n = 1'b1;
    chk("rel_s_ready_low", s_ready, 0);
    tick();
    chk("rel_s_ready_high", s_ready, 1);

    // Back-to-back frame of +15
    for (int i = 0; i < 40; i++) tx[i] = 15;
    send(40, 39, 1'b0);
    chk("f1_in_ready", in_ready, 1); chk("f1_s_ready", s_ready, 0); chk("f1_busy", busy, 1);
    check_slots("f1");

    // One ready flag per cycle, each for a single cycle
    for (int k = 0; k < 8; k++) begin
      fl = 8'(1 << k);
      tick();
      if (k < 7) chk("f1_done_early", done, 0);
    end
    fl = '0;
    chk("f1_done", done, 1); chk("f1_err", err, 0); chk("f1_gap_in_ready", in_ready, 0);
    for (int g = 0; g < 4; g++) begin
      chk("gap_s_ready", s_ready, 0); chk("gap_in_ready", in_ready, 0); chk("gap_busy", busy, 1);
      if (g > 0) chk("gap_done_pulse", done, 0);
      tick();
    end
    chk("gap_end_s_ready", s_ready, 1); chk("gap_end_busy", busy, 0);

    // Early s_last on beat 10
    for (int i = 0; i < 40; i++) tx[i] = 3;
    send(11, 10, 1'b0);
    chk("fe_err", err, 1); chk("fe_in_ready", in_ready, 0); chk("fe_s_ready", s_ready, 1);
    tick();
    chk("fe_err_pulse", err, 0);

    // Full frame of -16, then no flags until timeout
    for (int i = 0; i < 40; i++) tx[i] = -16;
    send(40, 39, 1'b0);
    chk("f2_in_ready", in_ready, 1);
    check_slots("f2");
    for (int c = 0; c < 63; c++) tick();
    chk("to_err_early", err, 0); chk("to_in_ready_held", in_ready, 1);
    tick();
    chk("to_err", err, 1); chk("to_done", done, 0); chk("to_in_ready", in_ready, 0);
    check_slots("f2_hold");
    wait_load();

    // s_valid toggling, distinct values per slot
    for (int i = 0; i < 40; i++) tx[i] = ((i * 5 + 7) % 32) - 16;
    send(40, 39, 1'b1);
    chk("f3_in_ready", in_ready, 1);
    check_slots("f3");

    // Completion on the same cycle as the timeout: done wins
    for (int c = 0; c < 63; c++) tick();
    fl = 8'hff;
    tick();
    fl = '0;
    chk("tie_done", done, 1); chk("tie_err", err, 0);
    wait_load();

    // Asynchronous reset in the middle of RUN
    for (int i = 0; i < 40; i++) tx[i] = 15 - i;
    send(40, 39, 1'b0);
    tick(); tick();
    chk("mr_in_ready_before", in_ready, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_in_ready", in_ready, 0); chk("mr_s_ready", s_ready, 0); chk("mr_busy", busy, 0);
    for (int i = 0; i < 40; i++) chk($sformatf("mr_zero[%0d]", i), obs[i], 0);
    tick();
    rst_n = 1'b1;
    chk("mr_rel_s_ready_low", s_ready, 0);
    tick();
    chk("mr_rel_s_ready", s_ready, 1); chk("mr_rel_in_ready", in_ready, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gnn_loader.md
GNN_LOADER -- requirements
Module: gnn_loader

Interface
REQ-001 Parameter: HOLD_CYCLES, default 4, number of cycles in_ready is held low between frames.
REQ-002 Parameter: TIMEOUT, default 64, maximum cycles in RUN before all eight ready flags are seen.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 Port: clk, input, 1, rising-edge clock.
REQ-005 Port: rst_n, input, 1, asynchronous active-low reset.
REQ-006 Port: s_valid, input, 1, stream beat valid.
REQ-007 Port: s_data, input, 5, signed stream beat payload.
REQ-008 Port: s_last, input, 1, marks final beat of a frame.
REQ-009 Port: s_ready, output, 1, loader accepts beat.
REQ-010 Port: x{0..3}_node{0..3}, output, 5 each, signed node features (16 ports).
REQ-011 Port: w{0..3}{4..7}, output, 5 each, signed layer-1 weights (16 ports).
REQ-012 Port: w{4..7}{8,9}, output, 5 each, signed layer-2 weights (8 ports).
REQ-013 Port: in_ready, output, 1, frame valid to the downstream gnn stage.
REQ-014 Port: out{0,1}_ready_node{0..3}, input, 1 each, ready flags returned by the gnn stage (8 ports).
REQ-015 Port: done, output, 1, one-cycle pulse on frame completion.
REQ-016 Port: err, output, 1, one-cycle pulse on framing error or timeout.
REQ-017 Port: busy, output, 1, high in RUN or GAP.

Function
REQ-018 A beat SHALL transfer on a rising edge when s_valid and s_ready are both 1.
REQ-019 Frame length SHALL be 40 beats, indexed 0..39.
REQ-020 Beats 0..15 SHALL be x0_node0, x1_node0, x2_node0, x3_node0, x0_node1, ... x3_node3.
REQ-021 Beats 16..31 SHALL be w04, w14, w24, w34, w05, ... w37.
REQ-022 Beats 32..39 SHALL be w48, w58, w68, w78, w49, w59, w69, w79.
REQ-023 States: LOAD, RUN, GAP. LOAD is entered after reset.
REQ-024 In LOAD: s_ready=1, in_ready=0, and each accepted beat writes its slot and increments the 6-bit index.
REQ-025 Beat 39 accepted with s_last=1: next cycle state=RUN, s_ready=0, in_ready=1, index=0.
REQ-026 s_last=1 on index<39, or s_last=0 on index 39: err pulse next cycle, index=0, remain in LOAD; slots already written keep their values.
REQ-027 In RUN: in_ready=1, and an 8-bit sticky mask ORs in the ready flags each cycle.
REQ-028 When (mask | current flags) is all ones: done pulse next cycle, then GAP.
REQ-029 When the RUN cycle count reaches TIMEOUT without completion: err pulse next cycle, then GAP.
REQ-030 If completion and timeout occur in the same cycle, done SHALL win and err SHALL stay 0.
REQ-031 In GAP: in_ready=0, s_ready=0, for exactly HOLD_CYCLES cycles; then LOAD with s_ready=1 and mask cleared.
REQ-032 x/w outputs SHALL be registered and SHALL change only on accepted beats; they hold stable through RUN and GAP.
REQ-033 Payload SHALL pass unmodified as 5-bit two's complement.

Reset
REQ-034 rst_n low SHALL immediately force: all x/w outputs=0, in_ready=0, s_ready=0, done=0, err=0, busy=0, index=0, mask=0, state=LOAD.
REQ-035 s_ready SHALL rise on the first rising edge after rst_n deasserts.
REQ-036 Reset asserted mid-RUN SHALL drop in_ready asynchronously and discard the frame.

Structure
REQ-037 Package gnn_pkg SHALL hold DATA_W=5, NUM_NODES=4, NUM_FEAT=4, NUM_HID=4, NUM_OUT=2, FRAME_LEN=40, and the state enum.
REQ-038 The ready mask plus timeout counter SHALL be a sub-module named gnn_ready_tracker.

Verification
REQ-039 Back-to-back 40 beats of 5'b01111 with s_last on beat 39 -> all 40 outputs = 15; in_ready=1 the cycle after beat 39; s_ready=0.
REQ-040 Eight ready flags raised one per cycle, each held for 1 cycle only -> done pulses one cycle after the 8th flag; in_ready=0 for 4 cycles; then s_ready=1.
REQ-041 s_last on beat 10 -> err pulse; in_ready stays 0; next full 40-beat frame of 5'b10000 -> all outputs = -16.
REQ-042 No ready flags in RUN -> err pulse after 64 cycles, then GAP; x/w outputs unchanged.
REQ-043 s_valid toggling every other cycle during a frame -> only handshaked beats are written; slot order is preserved.
REQ-044 rst_n pulsed low for 1 cycle mid-RUN -> in_ready=0 and all outputs=0 immediately; s_ready=1 on the first edge after release.
